// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding and hazard unit for the 5-stage MIPS pipeline.
// Lives in ID. Tracks a DEPTH-deep history of in-flight destinations (entry k =
// instruction k+1 stages ahead of ID). It produces registered forward selects
// for EX, combinational compare selects for ID-stage branches, and a one-bubble
// stall request for load-use hazards.
// Optional build macro FWD_BRANCH_STALL_EN: branches whose compare operands are
// not ready in time (ALU result in entry0, or a load in entry1) also stall, and
// the compare selects never pick entry0.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ISSUE,
    input  logic              FREEZE_IN,
    input  logic [REG_AW-1:0] SRC_A,
    input  logic              SRC_A_VLD,
    input  logic [REG_AW-1:0] SRC_B,
    input  logic              SRC_B_VLD,
    input  logic [REG_AW-1:0] SRC_M,
    input  logic              SRC_M_VLD,
    input  logic [REG_AW-1:0] DST,
    input  logic              DST_VLD,
    input  logic              IS_LOAD,
    input  logic              IS_BRANCH,
    output logic [SEL_W-1:0]  FWD_A_SEL,
    output logic [SEL_W-1:0]  FWD_B_SEL,
    output logic [SEL_W-1:0]  FWD_M_SEL,
    output logic [SEL_W-1:0]  CMP_A_SEL,
    output logic [SEL_W-1:0]  CMP_B_SEL,
    output logic              STALL_REQ
);

`ifdef FWD_BRANCH_STALL_EN
    // entry0 can never feed the ID compare in time; that case stalls instead
    localparam int CMP_LO = 1;
`else
    localparam int CMP_LO = 0;
`endif

    logic [DEPTH-1:0][REG_AW-1:0] dst_q, dst_d;
    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0]             load_q, load_d;
    logic [SEL_W-1:0]             fwd_a_q, fwd_a_d;
    logic [SEL_W-1:0]             fwd_b_q, fwd_b_d;
    logic [SEL_W-1:0]             fwd_m_q, fwd_m_d;
    logic [DEPTH-1:0]             m_a, m_b, m_m;
    logic                         lu_stall, br_stall;

    // Youngest matching entry at or beyond entry lo wins; no match gives 0.
    function automatic logic [SEL_W-1:0] pick(input logic [DEPTH-1:0] m, input int lo);
        logic [SEL_W-1:0] s;
        s = '0;
        for (int k = DEPTH-1; k >= 0; k--)
            if (m[k] && k >= lo) s = SEL_W'(k+1);
        return s;
    endfunction

    // Per-entry match vectors; register 0 never matches.
    always_comb begin
        m_a = '0;
        m_b = '0;
        m_m = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m_a[k] = SRC_A_VLD && vld_q[k] && (dst_q[k] != '0) && (dst_q[k] == SRC_A);
            m_b[k] = SRC_B_VLD && vld_q[k] && (dst_q[k] != '0) && (dst_q[k] == SRC_B);
            m_m[k] = SRC_M_VLD && vld_q[k] && (dst_q[k] != '0) && (dst_q[k] == SRC_M);
        end
    end

    assign lu_stall = ISSUE && load_q[0] && (m_a[0] || m_b[0] || m_m[0]);

    generate
`ifdef FWD_BRANCH_STALL_EN
        if (DEPTH > 1) begin : g_br1
            assign br_stall = ISSUE && IS_BRANCH &&
                              (m_a[0] || m_b[0] || (load_q[1] && (m_a[1] || m_b[1])));
        end else begin : g_br0
            assign br_stall = ISSUE && IS_BRANCH && (m_a[0] || m_b[0]);
        end
`else
        if (1) begin : g_nobr
            assign br_stall = 1'b0;
        end
`endif
    endgenerate

    assign STALL_REQ = lu_stall || br_stall;
    assign CMP_A_SEL = pick(m_a, CMP_LO);
    assign CMP_B_SEL = pick(m_b, CMP_LO);
    assign FWD_A_SEL = fwd_a_q;
    assign FWD_B_SEL = fwd_b_q;
    assign FWD_M_SEL = fwd_m_q;

    // Next history and selects: hold on freeze, bubble on stall, else shift in ID.
    always_comb begin
        dst_d   = dst_q;
        vld_d   = vld_q;
        load_d  = load_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        fwd_m_d = fwd_m_q;
        if (!FREEZE_IN) begin
            for (int k = 1; k < DEPTH; k++) begin
                dst_d[k]  = dst_q[k-1];
                vld_d[k]  = vld_q[k-1];
                load_d[k] = load_q[k-1];
            end
            if (STALL_REQ) begin
                vld_d[0]  = 1'b0;
                load_d[0] = 1'b0;
                fwd_a_d   = '0;
                fwd_b_d   = '0;
                fwd_m_d   = '0;
            end else begin
                dst_d[0]  = DST;
                vld_d[0]  = DST_VLD && ISSUE;
                load_d[0] = IS_LOAD && ISSUE;
                fwd_a_d   = ISSUE ? pick(m_a, 0) : '0;
                fwd_b_d   = ISSUE ? pick(m_b, 0) : '0;
                fwd_m_d   = ISSUE ? pick(m_m, 0) : '0;
            end
        end
    end

    // State registers; reset empties the history and clears the EX selects.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            dst_q   <= '0;
            vld_q   <= '0;
            load_q  <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
            fwd_m_q <= '0;
        end else begin
            dst_q   <= dst_d;
            vld_q   <= vld_d;
            load_q  <= load_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            fwd_m_q <= fwd_m_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors with hand-computed expectations, DEPTH=3.
module tb_fwd_hazard_unit;
    logic       CLK = 1'b0;
    logic       RESET, ISSUE, FREEZE_IN;
    logic [4:0] SRC_A, SRC_B, SRC_M, DST;
    logic       SRC_A_VLD, SRC_B_VLD, SRC_M_VLD, DST_VLD, IS_LOAD, IS_BRANCH;
    logic [1:0] FWD_A_SEL, FWD_B_SEL, FWD_M_SEL, CMP_A_SEL, CMP_B_SEL;
    logic       STALL_REQ;
    int         nchk = 0;
    int         nerr = 0;

    fwd_hazard_unit #(.REG_AW(5), .DEPTH(3), .SEL_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .ISSUE(ISSUE), .FREEZE_IN(FREEZE_IN),
        .SRC_A(SRC_A), .SRC_A_VLD(SRC_A_VLD), .SRC_B(SRC_B), .SRC_B_VLD(SRC_B_VLD),
        .SRC_M(SRC_M), .SRC_M_VLD(SRC_M_VLD), .DST(DST), .DST_VLD(DST_VLD),
        .IS_LOAD(IS_LOAD), .IS_BRANCH(IS_BRANCH),
        .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL), .FWD_M_SEL(FWD_M_SEL),
        .CMP_A_SEL(CMP_A_SEL), .CMP_B_SEL(CMP_B_SEL), .STALL_REQ(STALL_REQ));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Present one ID instruction (source valids derived from nonzero flags).
    task automatic drv(input logic iss, input logic [4:0] a, input logic av,
                       input logic [4:0] b, input logic bv, input logic [4:0] m,
                       input logic mv, input logic [4:0] d, input logic dv,
                       input logic ld, input logic br);
        ISSUE = iss; SRC_A = a; SRC_A_VLD = av; SRC_B = b; SRC_B_VLD = bv;
        SRC_M = m; SRC_M_VLD = mv; DST = d; DST_VLD = dv; IS_LOAD = ld; IS_BRANCH = br;
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0; FREEZE_IN = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #11;
        chk("rst_fwd_a", FWD_A_SEL, 0);
        chk("rst_fwd_b", FWD_B_SEL, 0);
        chk("rst_fwd_m", FWD_M_SEL, 0);
        chk("rst_stall", STALL_REQ, 0);
        RESET = 1'b1;

        // back-to-back: add r3 ; add r4,r3,r5
        drv(1, 1, 1, 2, 1, 0, 0, 3, 1, 0, 0); step();
        drv(1, 3, 1, 5, 1, 0, 0, 4, 1, 0, 0);
        chk("b2b_stall", STALL_REQ, 0);
`ifdef FWD_BRANCH_STALL_EN
        chk("b2b_cmp_a", CMP_A_SEL, 0);
`else
        chk("b2b_cmp_a", CMP_A_SEL, 1);
`endif
        step();
        chk("b2b_fwd_a", FWD_A_SEL, 1);
        chk("b2b_fwd_b", FWD_B_SEL, 0);

        // double writer: r3, r3, then read r3 -> youngest (1)
        drv(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0); step();
        drv(1, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0); step();
        drv(1, 3, 1, 0, 0, 0, 0, 7, 1, 0, 0);
`ifdef FWD_BRANCH_STALL_EN
        chk("dbl_cmp_a", CMP_A_SEL, 2);
`else
        chk("dbl_cmp_a", CMP_A_SEL, 1);
`endif
        step();
        chk("dbl_fwd_a", FWD_A_SEL, 1);

        // no issue: bubble, selects register as 0 even though r3 would match
        drv(0, 3, 1, 0, 0, 0, 0, 5, 1, 0, 0); step();
        chk("idle_fwd_a", FWD_A_SEL, 0);
        // read r3 now only in entry2 -> select 3
        drv(1, 3, 1, 5, 1, 0, 0, 0, 0, 0, 0); step();
        chk("old_fwd_a", FWD_A_SEL, 3);
        chk("old_fwd_b", FWD_B_SEL, 0);

        // load-use: lw r2 (reads r7 in entry2) ; add r6,r9,r2
        drv(1, 7, 1, 0, 0, 0, 0, 2, 1, 1, 0); step();
        chk("lw_fwd_a", FWD_A_SEL, 3);
        drv(1, 9, 1, 2, 1, 0, 0, 6, 1, 0, 0);
        chk("lu_stall", STALL_REQ, 1);
        step();
        chk("lu_bub_a", FWD_A_SEL, 0);
        chk("lu_bub_b", FWD_B_SEL, 0);
        chk("lu_stall_once", STALL_REQ, 0);
        step();
        chk("lu_fwd_b", FWD_B_SEL, 2);
        chk("lu_fwd_a", FWD_A_SEL, 0);

        // load feeding store data: lw r10 ; sw r10
        drv(1, 29, 1, 0, 0, 0, 0, 10, 1, 1, 0); step();
        drv(1, 29, 1, 0, 0, 10, 1, 0, 0, 0, 0);
        chk("sw_stall", STALL_REQ, 1);
        step();
        chk("sw_stall_once", STALL_REQ, 0);
        step();
        chk("sw_fwd_m", FWD_M_SEL, 2);

        // r0: lw r0 then write r0 then read r0 everywhere
        drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step();
        drv(1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        chk("r0_stall", STALL_REQ, 0);
        chk("r0_cmp_a", CMP_A_SEL, 0);
        chk("r0_cmp_b", CMP_B_SEL, 0);
        step();
        chk("r0_fwd_a", FWD_A_SEL, 0);
        chk("r0_fwd_b", FWD_B_SEL, 0);
        chk("r0_fwd_m", FWD_M_SEL, 0);

        // freeze: r12, r13, add r11,r12 (sel 2), then read r11 under freeze
        drv(1, 0, 0, 0, 0, 0, 0, 12, 1, 0, 0); step();
        drv(1, 0, 0, 0, 0, 0, 0, 13, 1, 0, 0); step();
        drv(1, 12, 1, 0, 0, 0, 0, 11, 1, 0, 0); step();
        chk("frz_pre_a", FWD_A_SEL, 2);
        FREEZE_IN = 1'b1;
        drv(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_hold_a", FWD_A_SEL, 2);
`ifdef FWD_BRANCH_STALL_EN
            chk("frz_cmp_b", CMP_B_SEL, 0);
            chk("frz_cmp_a", CMP_A_SEL, 0);
`else
            chk("frz_cmp_a", CMP_A_SEL, 1);
`endif
        end
        FREEZE_IN = 1'b0;
        step();
        chk("frz_post_a", FWD_A_SEL, 1);

        // freeze beats stall: lw r14 ; read r14 with freeze
        drv(1, 0, 0, 0, 0, 0, 0, 14, 1, 1, 0); step();
        FREEZE_IN = 1'b1;
        drv(1, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fs_stall", STALL_REQ, 1);
        step();
        chk("fs_stall_hold", STALL_REQ, 1);
        FREEZE_IN = 1'b0;
        step();
        chk("fs_stall_done", STALL_REQ, 0);
        step();
        chk("fs_fwd_a", FWD_A_SEL, 2);

        // lw r8 ; beq r8,r9
        drv(1, 0, 0, 0, 0, 0, 0, 8, 1, 1, 0); step();
        drv(1, 8, 1, 9, 1, 0, 0, 0, 0, 0, 1);
        chk("lbr_stall1", STALL_REQ, 1);
        chk("lbr_cmp_b", CMP_B_SEL, 0);
        step();
`ifdef FWD_BRANCH_STALL_EN
        chk("lbr_stall2", STALL_REQ, 1);
        step();
        chk("lbr_stall3", STALL_REQ, 0);
        chk("lbr_cmp_a", CMP_A_SEL, 3);
`else
        chk("lbr_stall2", STALL_REQ, 0);
        chk("lbr_cmp_a", CMP_A_SEL, 2);
`endif
        step();

        // add r8 ; beq r8,r9
        drv(1, 0, 0, 0, 0, 0, 0, 8, 1, 0, 0); step();
        drv(1, 8, 1, 9, 1, 0, 0, 0, 0, 0, 1);
`ifdef FWD_BRANCH_STALL_EN
        chk("abr_stall1", STALL_REQ, 1);
        step();
        chk("abr_stall2", STALL_REQ, 0);
        chk("abr_cmp_a", CMP_A_SEL, 2);
`else
        chk("abr_stall", STALL_REQ, 0);
        chk("abr_cmp_a", CMP_A_SEL, 1);
`endif
        step();

        // reset mid-operation with a pending load-use stall
        drv(1, 8, 1, 0, 0, 0, 0, 16, 1, 1, 0); step();
        drv(1, 16, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mr_stall_pre", STALL_REQ, 1);
        RESET = 1'b0;
        #1;
        chk("mr_stall", STALL_REQ, 0);
        chk("mr_cmp_a", CMP_A_SEL, 0);
        chk("mr_fwd_a", FWD_A_SEL, 0);
        RESET = 1'b1;
        step();
        chk("mr_post_a", FWD_A_SEL, 0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule
